sr_flag_arbiter: RTL

Round-robin arbiter and sequencer that shares a bank of NFLAG `sr_ff` flag flip-flops among NREQ requesters. Each requester asks to set or clear one flag. The arbiter drives a single-cycle S or R pulse into the bank, then reads back Q to confirm the write and returns a registered grant with an error bit. It sits between the control agents and the flag bank, and it never drives the forbidden S=R=1 combination.

---
 rtl/sr_flag_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that sequences single-cycle set/clear strobes into a
// bank of SR flag flip-flops, reads the flag back and returns a grant with an error bit.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 6,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NFLAG-1:0]     Q,
  output logic [NFLAG-1:0]     S,
  output logic [NFLAG-1:0]     R,
  output logic [NREQ-1:0]      gnt,
  output logic                 err,
  output logic                 busy
);

  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, RESP} state_t;

  state_t           state_q;
  logic [RRW-1:0]   rrLast_q;
  logic             op_q;
  logic [IDXW-1:0]  idx_q;
  logic             badIdx_q;
  logic [NFLAG-1:0] S_q, R_q;
  logic [NREQ-1:0]  gnt_q;
  logic             err_q;
  logic             busy_q;

  logic [RRW-1:0]   winner_d;
  logic             found_d;
  logic             opSel_d;
  logic [IDXW-1:0]  idxSel_d;
  logic             badSel_d;
  logic [NFLAG-1:0] flagHot_d;
  logic             qAtIdx_d;

  // Search upward from the last winner, wrapping, so each requester gets a turn.
  always_comb begin
    winner_d = rrLast_q;
    found_d  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found_d && req[(int'(rrLast_q) + i) % NREQ]) begin
        winner_d = RRW'((int'(rrLast_q) + i) % NREQ);
        found_d  = 1'b1;
      end
    end
  end

  always_comb begin
    opSel_d   = req_op[winner_d];
    idxSel_d  = req_idx[int'(winner_d)*IDXW +: IDXW];
    badSel_d  = (int'(idxSel_d) >= NFLAG);
    flagHot_d = '0;
    qAtIdx_d  = 1'b0;
    for (int f = 0; f < NFLAG; f++) begin
      if (int'(idxSel_d) == f) flagHot_d[f] = 1'b1;
      if (int'(idx_q) == f)    qAtIdx_d     = Q[f];
    end
  end

  // rrLast_q doubles as the latched winner for the transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rrLast_q <= RRW'(NREQ - 1);
      op_q     <= 1'b0;
      idx_q    <= '0;
      badIdx_q <= 1'b0;
      S_q      <= '0;
      R_q      <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= '0;
          err_q <= 1'b0;
          if (found_d) begin
            rrLast_q <= winner_d;
            op_q     <= opSel_d;
            idx_q    <= idxSel_d;
            badIdx_q <= badSel_d;
            S_q      <= opSel_d ? flagHot_d : '0;
            R_q      <= opSel_d ? '0 : flagHot_d;
            busy_q   <= 1'b1;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          S_q     <= '0;
          R_q     <= '0;
          state_q <= CHECK;
        end
        CHECK: begin
          gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << rrLast_q;
          err_q   <= badIdx_q | (qAtIdx_d != op_q);
          state_q <= RESP;
        end
        RESP: begin
          gnt_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S    = S_q;
  assign R    = R_q;
  assign gnt  = gnt_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule
